s7_capture: RTL and testbench
=============================

Name: s7_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the time-multiplexed segment and select lines, debounces each digit dwell, and decodes the segment patterns back to BCD.
- Once every digit position has been captured, presents a complete BCD frame with a one-cycle valid strobe.
- Used as a bench/loopback checker and as a front end for reading an external multiplexed display.

Parameters:
- DIS_NUM, 4: number of digit positions; width of select bus.
- STABLE_CNT, 3: consecutive identical samples required before a digit is accepted; minimum 1.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_segments  input  7  segment lines; bit0=a … bit6=g; 1 = segment lit.
- i_segments_sel  input  DIS_NUM  digit select, active-high, one-hot; bit k selects BCD nibble k.
- o_bcd_data  output  DIS_NUM*4  last complete frame; nibble k = [4k+3:4k].
- o_valid  output  1  one-cycle pulse when o_bcd_data is updated.
- o_digit_err  output  DIS_NUM  per-digit invalid-pattern flags for the frame in o_bcd_data.
- o_sel_err  output  1  one-cycle pulse: registered select was multi-hot.

Behaviour:
- Reset: one clock, synchronous active-high on i_rst. All registers clear. o_bcd_data=0, o_valid=0, o_digit_err=0, o_sel_err=0. Internal state also clears: sample regs, counter, accepted flag, frame mask, shadow data, shadow error. Reset mid-frame discards the partial frame.
- Input stage: i_segments and i_segments_sel are registered once (s_seg, s_sel) every cycle.
- Stability counter cnt:
  - Resets to 0 when {s_seg,s_sel} differs from the previous cycle's value, or when s_sel is not one-hot.
  - Otherwise increments, saturating at STABLE_CNT-1.
  - The accepted flag clears whenever cnt resets.
- Accept: when cnt==STABLE_CNT-1, s_sel is one-hot and the accepted flag is 0, the next edge:
  - writes the decoded nibble into shadow slot k (k = index of the set bit in s_sel);
  - writes the error bit into shadow error slot k;
  - sets mask bit k and sets the accepted flag.
  - Exactly one accept per dwell.
- Latency: inputs stable from edge E → shadow write at edge E+STABLE_CNT+1.
- Decode (exact match, 7-bit hex): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9. Any other pattern, including 00 (blank) → nibble F, error bit 1.
- Re-capture: a digit accepted again before the frame completes overwrites its shadow slot. The mask bit stays set.
- Frame complete: on the accept edge where the mask becomes all ones:
  - o_bcd_data loads from shadow, including the slot being written that edge.
  - o_digit_err loads from shadow error.
  - o_valid = 1 for exactly that following cycle.
  - Mask clears to 0; shadow keeps its contents.
- Outputs hold between frames. o_valid is 0 except on the frame-complete cycle.
- Select all-zero (blanking gap): cnt reset; not an error; no effect on mask or shadow.
- Select multi-hot:
  - o_sel_err = 1 on the cycle after s_sel holds the multi-hot value; asserted every cycle it persists.
  - cnt reset; frame mask cleared (partial frame aborted).
  - o_bcd_data and o_digit_err unchanged.
- Order independence: digits may arrive in any order. A frame needs each of the DIS_NUM positions accepted at least once.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
- Reset check: assert i_rst 2 cycles with random inputs → all outputs 0; no o_valid during or 10 cycles after with inputs static at sel=0.
- Nominal frame (STABLE_CNT=3, DIS_NUM=4): drive sel 0001/0010/0100/1000 with segs 06, 5B, 4F, 66, 8-cycle dwell each → single o_valid pulse, o_bcd_data=16'h4321, o_digit_err=0.
  - Dwell-edge timing: first accept exactly 4 edges after dwell start.
- Glitch rejection: dwell on sel=0001 seg 3F, with seg toggling to 7F for 1 of every 2 cycles → no accept for that digit; o_valid never asserts.
  - Hold stable for 3+ cycles → accepted; nibble 0.
- Invalid pattern: digit 2 driven with seg 00, others valid 1,2,4 on digits 0,1,3 → o_bcd_data=16'h4F21, o_digit_err=4'b0100.
- Multi-hot abort: capture digits 0,1, then sel=0011 for 1 cycle → o_sel_err pulse 1 cycle.
  - Then capture digits 2,3 only → no o_valid.
  - Then capture 0,1 → o_valid, correct frame.
- Reset mid-frame and overwrite:
  - Capture digits 0–2, assert i_rst 1 cycle, capture digit 3 only → no o_valid.
  - Separately, capture digit 0 as 5, then as 9, then digits 1–3 → nibble 0 = 9, one o_valid.

Source files
------------

// File: rtl/s7_capture.sv
// s7_capture: receive side of a multiplexed 7-segment display link.
// Registers the segment/select lines, waits for each digit dwell to settle,
// decodes the lit pattern back to BCD and collects one nibble per digit
// position. When every position has been seen, the collected frame is
// published on o_bcd_data together with a one-cycle o_valid strobe.
module s7_capture #(
    parameter int DIS_NUM    = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [6:0]             i_segments,
    input  logic [DIS_NUM-1:0]     i_segments_sel,
    output logic [DIS_NUM*4-1:0]   o_bcd_data,
    output logic                   o_valid,
    output logic [DIS_NUM-1:0]     o_digit_err,
    output logic                   o_sel_err
);

    // Counter only has to reach STABLE_CNT-1, so size it for that range.
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);
    localparam logic [DIS_NUM-1:0] MASK_FULL = {DIS_NUM{1'b1}};

    // Input sample stage and the copy from the previous cycle.
    logic [6:0]             s_seg_reg;
    logic [DIS_NUM-1:0]     s_sel_reg;
    logic [6:0]             prev_seg_reg;
    logic [DIS_NUM-1:0]     prev_sel_reg;

    // Dwell tracking.
    logic [CNT_W-1:0]       cnt_reg;
    logic                   accepted_reg;

    // Frame assembly.
    logic [DIS_NUM-1:0]     mask_reg;
    logic [DIS_NUM*4-1:0]   shadow_data_reg;
    logic [DIS_NUM-1:0]     shadow_err_reg;

    // Output registers.
    logic [DIS_NUM*4-1:0]   bcd_reg;
    logic                   valid_reg;
    logic [DIS_NUM-1:0]     digit_err_reg;
    logic                   sel_err_reg;

    // Combinational helpers.
    logic                   sample_same;
    logic                   sel_onehot;
    logic                   sel_zero;
    logic                   sel_multi;
    logic                   dwell_break;
    logic                   accept;
    logic [3:0]             dec_nibble;
    logic                   dec_err;
    logic [DIS_NUM-1:0]     slot_we;
    logic [DIS_NUM-1:0]     mask_next;
    logic                   frame_done;
    logic [DIS_NUM*4-1:0]   frame_data_next;
    logic [DIS_NUM-1:0]     frame_err_next;

    // Register the raw pins once, and keep the previous sample for change detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_seg_reg    <= '0;
            s_sel_reg    <= '0;
            prev_seg_reg <= '0;
            prev_sel_reg <= '0;
        end else begin
            s_seg_reg    <= i_segments;
            s_sel_reg    <= i_segments_sel;
            prev_seg_reg <= s_seg_reg;
            prev_sel_reg <= s_sel_reg;
        end
    end

    // Classify the current sample: unchanged, one-hot, blank or multi-hot.
    always_comb begin
        sample_same = (s_seg_reg == prev_seg_reg) && (s_sel_reg == prev_sel_reg);
        sel_onehot  = $onehot(s_sel_reg);
        sel_zero    = (s_sel_reg == '0);
        sel_multi   = !sel_onehot && !sel_zero;
        dwell_break = !sample_same || !sel_onehot;
        // The unchanged-sample term also guards the cycle where the input moves
        // while the counter still shows the previous dwell at its maximum.
        accept      = sample_same && sel_onehot && !accepted_reg && (cnt_reg == CNT_MAX);
    end

    // Segment pattern to BCD; anything that is not a clean 0-9 glyph reads as F.
    always_comb begin
        dec_nibble = 4'hF;
        dec_err    = 1'b0;
        case (s_seg_reg)
            7'h3F:   dec_nibble = 4'h0;
            7'h06:   dec_nibble = 4'h1;
            7'h5B:   dec_nibble = 4'h2;
            7'h4F:   dec_nibble = 4'h3;
            7'h66:   dec_nibble = 4'h4;
            7'h6D:   dec_nibble = 4'h5;
            7'h7D:   dec_nibble = 4'h6;
            7'h07:   dec_nibble = 4'h7;
            7'h7F:   dec_nibble = 4'h8;
            7'h6F:   dec_nibble = 4'h9;
            default: begin
                dec_nibble = 4'hF;
                dec_err    = 1'b1;
            end
        endcase
    end

    // Count consecutive identical one-hot samples; one accept per dwell.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg      <= '0;
            accepted_reg <= 1'b0;
        end else if (dwell_break) begin
            cnt_reg      <= '0;
            accepted_reg <= 1'b0;
        end else begin
            if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (accept) begin
                accepted_reg <= 1'b1;
            end
        end
    end

    // Per-slot shadow storage and the frame that would be published this edge.
    // The frame view folds in the slot being written so the last digit is not lost.
    generate
        for (genvar gi = 0; gi < DIS_NUM; gi++) begin : g_slot
            assign slot_we[gi] = accept && s_sel_reg[gi];

            assign frame_data_next[gi*4 +: 4] = slot_we[gi] ? dec_nibble
                                                            : shadow_data_reg[gi*4 +: 4];
            assign frame_err_next[gi]         = slot_we[gi] ? dec_err
                                                            : shadow_err_reg[gi];

            // Capture the decoded digit into its slot on accept; re-capture overwrites.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    shadow_data_reg[gi*4 +: 4] <= 4'h0;
                    shadow_err_reg[gi]         <= 1'b0;
                end else if (slot_we[gi]) begin
                    shadow_data_reg[gi*4 +: 4] <= dec_nibble;
                    shadow_err_reg[gi]         <= dec_err;
                end
            end
        end
    endgenerate

    // Frame completes when this accept fills the last missing position.
    always_comb begin
        mask_next  = mask_reg | slot_we;
        frame_done = accept && (mask_next == MASK_FULL);
    end

    // Track which positions have arrived; multi-hot select aborts the partial frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mask_reg <= '0;
        end else if (sel_multi || frame_done) begin
            mask_reg <= '0;
        end else if (accept) begin
            mask_reg <= mask_next;
        end
    end

    // Publish completed frames and flag select errors; outputs hold between frames.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bcd_reg       <= '0;
            digit_err_reg <= '0;
            valid_reg     <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            valid_reg   <= frame_done;
            sel_err_reg <= sel_multi;
            if (frame_done) begin
                bcd_reg       <= frame_data_next;
                digit_err_reg <= frame_err_next;
            end
        end
    end

    assign o_bcd_data  = bcd_reg;
    assign o_valid     = valid_reg;
    assign o_digit_err = digit_err_reg;
    assign o_sel_err   = sel_err_reg;

endmodule

// File: tb/tb_s7_capture.sv
// Directed testbench for s7_capture (DIS_NUM=4, STABLE_CNT=3).
module tb_s7_capture;

    localparam int DIS_NUM    = 4;
    localparam int STABLE_CNT = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [6:0]           seg;
    logic [DIS_NUM-1:0]   sel;
    logic [DIS_NUM*4-1:0] bcd;
    logic                 valid;
    logic [DIS_NUM-1:0]   derr;
    logic                 serr;

    int n_checks    = 0;
    int n_fail      = 0;
    int valid_cnt   = 0;
    int sel_err_cnt = 0;
    int base_v;
    int base_s;

    s7_capture #(
        .DIS_NUM    (DIS_NUM),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_segments     (seg),
        .i_segments_sel (sel),
        .o_bcd_data     (bcd),
        .o_valid        (valid),
        .o_digit_err    (derr),
        .o_sel_err      (serr)
    );

    always #5 clk = ~clk;

    // Count strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
        if (serr === 1'b1) sel_err_cnt <= sel_err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one dwell and wait n edges; inputs change 1ns after an edge.
    task automatic dwell(input logic [3:0] s, input logic [6:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- Reset with random inputs ----
        rst = 1'b1;
        sel = 4'($urandom);
        seg = 7'($urandom);
        @(posedge clk);
        #1;
        sel = 4'($urandom);
        seg = 7'($urandom);
        @(posedge clk);
        #1;
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_derr", 32'(derr), 32'h0);
        check("reset_serr", 32'(serr), 32'h0);
        rst = 1'b0;
        dwell(4'b0000, 7'h00, 10);
        check("reset_no_valid", 32'(valid_cnt), 32'd0);
        $display("reset: bcd=%h valid_cnt=%0d", bcd, valid_cnt);

        // ---- Nominal frame 4321, with edge timing on the last digit ----
        base_v = valid_cnt;
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0100, 7'h4F, 8);
        sel = 4'b1000;
        seg = 7'h66;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("nominal_valid_edge%0d", i), 32'(valid), (i == STABLE_CNT + 2) ? 32'h1 : 32'h0);
        end
        check("nominal_bcd", 32'(bcd), 32'h4321);
        check("nominal_derr", 32'(derr), 32'h0);
        check("nominal_pulses", 32'(valid_cnt - base_v), 32'd1);
        $display("nominal: bcd=%h derr=%b pulses=%0d", bcd, derr, valid_cnt - base_v);
        dwell(4'b0000, 7'h00, 3);

        // ---- Glitch rejection on digit 0 ----
        base_v = valid_cnt;
        for (int i = 0; i < 12; i++) begin
            dwell(4'b0001, (i % 2 == 0) ? 7'h3F : 7'h7F, 1);
        end
        check("glitch_no_valid", 32'(valid_cnt - base_v), 32'd0);
        dwell(4'b0010, 7'h6D, 8);
        dwell(4'b0100, 7'h07, 8);
        dwell(4'b1000, 7'h7F, 8);
        check("glitch_digit0_missing", 32'(valid_cnt - base_v), 32'd0);
        dwell(4'b0001, 7'h3F, 8);
        check("glitch_then_stable", 32'(valid_cnt - base_v), 32'd1);
        check("glitch_bcd", 32'(bcd), 32'h8750);
        check("glitch_derr", 32'(derr), 32'h0);
        $display("glitch: bcd=%h pulses=%0d", bcd, valid_cnt - base_v);

        // ---- Invalid pattern on digit 2 ----
        base_v = valid_cnt;
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0100, 7'h00, 8);
        dwell(4'b1000, 7'h66, 8);
        check("invalid_pulses", 32'(valid_cnt - base_v), 32'd1);
        check("invalid_bcd", 32'(bcd), 32'h4F21);
        check("invalid_derr", 32'(derr), 32'h4);
        $display("invalid: bcd=%h derr=%b", bcd, derr);

        // ---- Multi-hot abort ----
        base_v = valid_cnt;
        base_s = sel_err_cnt;
        dwell(4'b0001, 7'h6D, 8);
        dwell(4'b0010, 7'h7D, 8);
        dwell(4'b0011, 7'h06, 1);
        sel = 4'b0100;
        seg = 7'h07;
        @(posedge clk);
        #1;
        check("multihot_serr_high", 32'(serr), 32'h1);
        @(posedge clk);
        #1;
        check("multihot_serr_low", 32'(serr), 32'h0);
        dwell(4'b0100, 7'h07, 6);
        dwell(4'b1000, 7'h7F, 8);
        check("multihot_serr_pulses", 32'(sel_err_cnt - base_s), 32'd1);
        check("multihot_no_valid", 32'(valid_cnt - base_v), 32'd0);
        check("multihot_bcd_held", 32'(bcd), 32'h4F21);
        check("multihot_derr_held", 32'(derr), 32'h4);
        dwell(4'b0001, 7'h6F, 8);
        dwell(4'b0010, 7'h3F, 8);
        check("multihot_recover_pulses", 32'(valid_cnt - base_v), 32'd1);
        check("multihot_recover_bcd", 32'(bcd), 32'h8709);
        check("multihot_recover_derr", 32'(derr), 32'h0);
        $display("multihot: bcd=%h serr_pulses=%0d", bcd, sel_err_cnt - base_s);

        // ---- Reset mid-frame discards the partial frame ----
        base_v = valid_cnt;
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0100, 7'h4F, 8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_bcd", 32'(bcd), 32'h0);
        dwell(4'b1000, 7'h66, 8);
        check("midreset_no_valid", 32'(valid_cnt - base_v), 32'd0);
        $display("midreset: bcd=%h pulses=%0d", bcd, valid_cnt - base_v);

        // ---- Overwrite of digit 0 before frame completes ----
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base_v = valid_cnt;
        dwell(4'b0001, 7'h6D, 8);
        dwell(4'b0000, 7'h00, 2);
        dwell(4'b0001, 7'h6F, 8);
        dwell(4'b0010, 7'h06, 8);
        dwell(4'b0100, 7'h5B, 8);
        dwell(4'b1000, 7'h4F, 8);
        check("overwrite_pulses", 32'(valid_cnt - base_v), 32'd1);
        check("overwrite_bcd", 32'(bcd), 32'h3219);
        check("overwrite_derr", 32'(derr), 32'h0);
        $display("overwrite: bcd=%h pulses=%0d", bcd, valid_cnt - base_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
